// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefDepth    = 16;
  localparam int unsigned DefAeThresh = 2;

  // Pointer width; never below one bit so degenerate depths still elaborate.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must represent 0..depth inclusive, hence the extra bit.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned def_af_thresh(input int unsigned depth);
    return (depth > 2) ? depth - 2 : depth;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO bus: write/read requests, error clear, read data, flags and occupancy.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) ();

  logic                      wr_en;
  logic [DATA_W-1:0]         wdata;
  logic                      rd_en;
  logic                      err_clr;
  logic [DATA_W-1:0]         rdata;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output wr_en, wdata, rd_en, err_clr,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en, err_clr,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port, one read port. SYNC_FIFO_FWFT_EN selects an
// asynchronous read; otherwise the read data is registered on accepted reads.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [ptr_w(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    re_i,
  input  logic [ptr_w(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]       rdata_o
);

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd;
  assign unused_rd = ^{re_i, rst_ni};
  assign rdata_o   = mem_q[raddr_i];
`else
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Samples the pre-write contents, so a full FIFO reading and writing the
  // same slot returns the old head.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, threshold flags and sticky
// errors. Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AF_THRESH = def_af_thresh(DEPTH),
  parameter int unsigned AE_THRESH = DefAeThresh
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Flags come only from the registered count, keeping request-to-output paths cut.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    wr_acc      = bus.wr_en && (!full || bus.rd_en);
    rd_acc      = bus.rd_en && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  && !bus.err_clr;
    underflow_d = underflow_q && !bus.err_clr;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end

    // A fresh error event beats a same-cycle clear.
    if (bus.wr_en && full && !bus.rd_en) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wdata),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rdata = empty ? '0 : mem_rdata;
`else
  assign bus.rdata = mem_rdata;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=16, DATA_W=8): vector table plus
// hand sequences for wrap-around, mid-burst reset and write-to-read latency.
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit Fwft = 1'b1;
`else
  localparam bit Fwft = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    logic [7:0] rdata;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t vecs[$];

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

  sync_fifo_param dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] rdata, input logic [4:0] cnt,
                             input logic full, input logic empty, input logic af,
                             input logic ae, input logic ovf, input logic unf);
    check({tag, ".rdata"}, 32'(bus.rdata), 32'(rdata));
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".full"}, 32'(bus.full), 32'(full));
    check({tag, ".empty"}, 32'(bus.empty), 32'(empty));
    check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(af));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(unf));
  endtask

  task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    @(negedge clk);
    bus.wr_en   = wr;
    bus.wdata   = wd;
    bus.rd_en   = rd;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  function automatic void add(input logic wr, input logic [7:0] wd, input logic rd,
                              input logic clr, input logic [7:0] rdata, input logic [4:0] cnt,
                              input logic ovf, input logic unf);
    vec_t v;
    v = '{wr: wr, wd: wd, rd: rd, clr: clr, rdata: rdata, cnt: cnt,
          full: (cnt == 5'd16), empty: (cnt == 5'd0), af: (cnt >= 5'd14),
          ae: (cnt <= 5'd2), ovf: ovf, unf: unf};
    vecs.push_back(v);
  endfunction

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wdata   = '0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;

    // Fill 0x01..0x10, overflow with 0xAA, drain, then error-flag corner cases.
    for (int i = 1; i <= 16; i++) begin
      add(1'b1, 8'(i), 1'b0, 1'b0, Fwft ? 8'h01 : 8'h00, 5'(i), 1'b0, 1'b0);
    end
    add(1'b1, 8'hAA, 1'b0, 1'b0, Fwft ? 8'h01 : 8'h00, 5'd16, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      add(1'b0, 8'h00, 1'b1, 1'b0, Fwft ? ((i < 16) ? 8'(i + 1) : 8'h00) : 8'(i),
          5'(16 - i), 1'b1, 1'b0);
    end
    add(1'b0, 8'h00, 1'b0, 1'b1, Fwft ? 8'h00 : 8'h10, 5'd0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, Fwft ? 8'h00 : 8'h10, 5'd0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, Fwft ? 8'h00 : 8'h10, 5'd0, 1'b0, 1'b1);
    add(1'b1, 8'h55, 1'b1, 1'b0, Fwft ? 8'h55 : 8'h10, 5'd1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, Fwft ? 8'h00 : 8'h55, 5'd0, 1'b0, 1'b0);

    #2;
    check_state("reset_held", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("reset_released", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      check_state($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].cnt, vecs[i].full,
                  vecs[i].empty, vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].unf);
    end

    // Full FIFO with simultaneous read and write for 20 cycles: pointers wrap.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
    end
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 8'(17 + j), 1'b1, 1'b0);
      check($sformatf("wrap%0d.count", j), 32'(bus.count), 32'd16);
      check($sformatf("wrap%0d.rdata", j), 32'(bus.rdata), Fwft ? 32'(j + 2) : 32'(j + 1));
      check($sformatf("wrap%0d.overflow", j), 32'(bus.overflow), 32'd0);
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check($sformatf("drain%0d.rdata", k), 32'(bus.rdata),
            Fwft ? ((k < 15) ? 32'(22 + k) : 32'd0) : 32'(21 + k));
    end
    check("drain.empty", 32'(bus.empty), 32'd1);

    // Raise underflow, write 5 words, then reset asynchronously mid-burst.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_reset.underflow", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    end
    bus.wr_en = 1'b1;
    bus.wdata = 8'hEE;
    #2;
    rst = 1'b0;
    #1;
    bus.wr_en = 1'b0;
    check_state("mid_reset", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("post_reset_wr.rdata", 32'(bus.rdata), Fwft ? 32'h77 : 32'h00);
    check("post_reset_wr.count", 32'(bus.count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_rd.rdata", 32'(bus.rdata), Fwft ? 32'h00 : 32'h77);
    check("post_reset_rd.empty", 32'(bus.empty), 32'd1);

    // Write-to-read latency on an empty FIFO.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("lat_wr.empty", 32'(bus.empty), 32'd0);
    check("lat_wr.rdata", 32'(bus.rdata), Fwft ? 32'h3C : 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_rd.rdata", 32'(bus.rdata), Fwft ? 32'h00 : 32'h3C);
    check("lat_rd.empty", 32'(bus.empty), 32'd1);
    check("lat_rd.underflow", 32'(bus.underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
